// File: rtl/mul_8_seq_if.sv
// Operand/result handshake between ALU control and the sequential 8x8 multiplier.
// Control drives start with the operands; the multiplier returns product with busy/done status.
interface mul_8_seq_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output A,
        output B,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/mul_8_seq.sv
// Iterative unsigned 8x8 -> 16 shift-and-add multiplier, one partial sum per clock.
// The partial sum comes from a single 8-bit adder; its carry is recovered by comparing sum against hi.

module adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);
    assign sum = a + b;
endmodule

module mul_8_seq #(
    parameter bit ZERO_SHORTCUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    mul_8_seq_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [7:0]  m_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [3:0]  cnt_q;
    logic [15:0] product_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  sum;
    logic        carry;
    logic [7:0]  hi_d;
    logic [7:0]  lo_d;
    logic        accept;
    logic        shortcut;
    logic        last;

    adder_8 u_adder (
        .a   (hi_q),
        .b   (m_q),
        .sum (sum)
    );

    // An 8-bit add wrapped around exactly when the result is smaller than an operand.
    assign carry = lo_q[0] & (sum < hi_q);

    // One iteration: conditionally add, then shift {carry, hi, lo} right by one.
    always_comb begin
        if (lo_q[0]) begin
            hi_d = {carry, sum[7:1]};
            lo_d = {sum[0], lo_q[7:1]};
        end else begin
            hi_d = {1'b0, hi_q[7:1]};
            lo_d = {hi_q[0], lo_q[7:1]};
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shortcut = 1'b0;
        last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (ZERO_SHORTCUT && (bus.A == 8'd0 || bus.B == 8'd0)) begin
                        shortcut = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt_q == 4'd7) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= 8'd0;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            cnt_q     <= 4'd0;
            product_q <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= shortcut | last;
            if (accept) begin
                m_q    <= bus.A;
                hi_q   <= 8'd0;
                lo_q   <= bus.B;
                cnt_q  <= 4'd0;
                busy_q <= 1'b1;
            end else if (state_q == RUN) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + 4'd1;
                if (last) begin
                    product_q <= {hi_d, lo_d};
                    busy_q    <= 1'b0;
                end
            end
            if (shortcut) begin
                product_q <= 16'h0000;
            end
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_mul_8_seq.sv
// Bench for mul_8_seq: runs both ZERO_SHORTCUT settings side by side on shared stimulus,
// comparing every cycle against a latency/product model built from plain multiplication.
module tb_mul_8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;

    int unsigned total_checks;
    int unsigned passed_checks;

    mul_8_seq_if bus0 ();
    mul_8_seq_if bus1 ();

    assign bus0.start = start;
    assign bus0.A     = a;
    assign bus0.B     = b;
    assign bus1.start = start;
    assign bus1.A     = a;
    assign bus1.B     = b;

    mul_8_seq #(.ZERO_SHORTCUT(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mul_8_seq #(.ZERO_SHORTCUT(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed_checks++;
        end
    endtask

    // Model: an accepted operation is a countdown of 8 edges carrying the product A*B.
    logic        m_busy [2];
    logic        m_done [2];
    logic [15:0] m_prod [2];
    logic [15:0] m_pend [2];
    int          m_left [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_prod[i] <= 16'h0000;
                m_pend[i] <= 16'h0000;
                m_left[i] <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (start) begin
                        if (i == 1 && (a == 8'd0 || b == 8'd0)) begin
                            m_prod[i] <= 16'h0000;
                            m_done[i] <= 1'b1;
                        end else begin
                            m_busy[i] <= 1'b1;
                            m_left[i] <= 8;
                            m_pend[i] <= 16'(a) * 16'(b);
                        end
                    end
                end else begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_prod[i] <= m_pend[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy0",    32'(bus0.busy),    32'(m_busy[0]));
        check("done0",    32'(bus0.done),    32'(m_done[0]));
        check("product0", 32'(bus0.product), 32'(m_prod[0]));
        check("busy1",    32'(bus1.busy),    32'(m_busy[1]));
        check("done1",    32'(bus1.done),    32'(m_done[1]));
        check("product1", 32'(bus1.product), 32'(m_prod[1]));
        check("done_busy_excl", 32'((bus0.done & bus0.busy) | (bus1.done & bus1.busy)), 32'd0);
    end

    // Called at a falling edge; returns at the falling edge where the slower DUT shows done.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [15:0] exp_prod, input int exp_lat0, input int exp_lat1,
                          input int glitch_at);
        int lat0;
        int lat1;
        int dones0;
        lat0   = 0;
        lat1   = 0;
        dones0 = 0;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (bus0.done) dones0++;
            if (bus0.done && lat0 == 0) lat0 = n;
            if (bus1.done && lat1 == 0) lat1 = n;
            if (lat0 != 0 && lat1 != 0) break;
            if (n == glitch_at) begin
                a     = 8'd9;
                b     = 8'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("latency0", 32'(lat0), 32'(exp_lat0));
        check("latency1", 32'(lat1), 32'(exp_lat1));
        check("done_pulses0", 32'(dones0), 32'd1);
        check("result0", 32'(bus0.product), 32'(exp_prod));
        check("result1", 32'(bus1.product), 32'(exp_prod));
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        rst   = 1'b1;
        #1;
        check("rst_product", 32'(bus0.product), 32'h0000);
        check("rst_busy",    32'(bus0.busy | bus1.busy), 32'd0);
        check("rst_done",    32'(bus0.done | bus1.done), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_product", 32'(bus1.product), 32'h0000);

        run_op(8'd13,  8'd11,  16'h008F, 9, 9, 0);
        run_op(8'd255, 8'd255, 16'hFE01, 9, 9, 0);
        run_op(8'd128, 8'd2,   16'h0100, 9, 9, 0);
        run_op(8'd0,   8'd77,  16'h0000, 9, 1, 0);
        @(negedge clk);
        run_op(8'd7,   8'd6,   16'h002A, 9, 9, 3);

        // Reset in the middle of a run: outputs must clear without a clock edge.
        @(negedge clk);
        a     = 8'd200;
        b     = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_busy",    32'(bus0.busy | bus1.busy), 32'd0);
        check("midrun_rst_done",    32'(bus0.done | bus1.done), 32'd0);
        check("midrun_rst_product", 32'(bus0.product), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd200, 8'd3, 16'h0258, 9, 9, 0);
        run_op(8'd2,   8'd3, 16'h0006, 9, 9, 0);

        for (int t = 0; t < 30; t++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, 16'(ra) * 16'(rb), 9,
                   (ra == 8'd0 || rb == 8'd0) ? 1 : 9, 0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
